// File: rtl/cache_pkg.sv
// Shared types and default geometry for the 2-way set-associative cache controller.
package cache_pkg;

    localparam int unsigned ADDR_WIDTH_D  = 32;
    localparam int unsigned N_WAYS_D      = 2;
    localparam int unsigned NUM_SETS_D    = 32;
    localparam int unsigned OFFSET_BITS_D = 7;
    localparam int unsigned INDEX_BITS_D  = 5;
    localparam int unsigned TAG_BITS_D    = 20;

    typedef logic [TAG_BITS_D-1:0]    tag_t;
    typedef logic [INDEX_BITS_D-1:0]  index_t;
    typedef logic [OFFSET_BITS_D-1:0] offset_t;

    typedef struct packed {
        tag_t    tag;
        index_t  index;
        offset_t offset;
    } addr_fields_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_RESPOND
    } state_t;

    function automatic addr_fields_t split_addr(input logic [ADDR_WIDTH_D-1:0] addr);
        return addr_fields_t'(addr);
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU, memory and data-array signal bundle; master = controller side, slave = environment side.
interface cache_controller_if import cache_pkg::*; #(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_D,
    parameter int unsigned INDEX_BITS  = INDEX_BITS_D,
    parameter int unsigned OFFSET_BITS = OFFSET_BITS_D
) ();

    logic                   cpu_req_valid;
    logic                   cpu_req_we;
    logic [ADDR_WIDTH-1:0]  cpu_req_addr;
    logic                   cpu_req_ready;
    logic                   cpu_resp_valid;
    logic                   cpu_resp_hit;

    logic                   mem_req_valid;
    logic                   mem_req_we;
    logic [ADDR_WIDTH-1:0]  mem_req_addr;
    logic                   mem_req_ready;
    logic                   mem_resp_valid;

    logic                   arr_way;
    logic [INDEX_BITS-1:0]  arr_index;
    logic [OFFSET_BITS-1:0] arr_offset;
    logic                   arr_cpu_we;
    logic                   arr_fill_we;

    modport master (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, mem_req_ready, mem_resp_valid,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_hit,
        output mem_req_valid, mem_req_we, mem_req_addr,
        output arr_way, arr_index, arr_offset, arr_cpu_we, arr_fill_we
    );

    modport slave (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, mem_req_ready, mem_resp_valid,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_hit,
        input  mem_req_valid, mem_req_we, mem_req_addr,
        input  arr_way, arr_index, arr_offset, arr_cpu_we, arr_fill_we
    );

endinterface

// File: rtl/lru_tracker.sv
// One LRU bit per set naming the way to evict next; updated with the way just used.
module lru_tracker #(
    parameter int unsigned NUM_SETS   = 32,
    parameter int unsigned INDEX_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_lru,
    input  logic                  i_upd_en,
    input  logic [INDEX_BITS-1:0] i_upd_index,
    input  logic                  i_upd_way
);

    logic [NUM_SETS-1:0] r_lru;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lru <= '0;
        end else if (i_upd_en) begin
            r_lru[i_upd_index] <= ~i_upd_way;
        end
    end

    assign o_rd_lru = r_lru[i_rd_index];

endmodule

// File: rtl/cache_controller.sv
// Blocking 2-way write-back cache controller (tags/state only; data array is external).
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_controller import cache_pkg::*; #(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_D,
    parameter int unsigned N_WAYS      = N_WAYS_D,
    parameter int unsigned NUM_SETS    = NUM_SETS_D,
    parameter int unsigned OFFSET_BITS = OFFSET_BITS_D,
    parameter int unsigned INDEX_BITS  = INDEX_BITS_D,
    parameter int unsigned TAG_BITS    = TAG_BITS_D
) (
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.master cache_if
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    state_t r_state, w_next_state;

    logic                   r_req_we;
    logic [ADDR_WIDTH-1:0]  r_req_addr;
    logic                   r_way;
    logic                   r_hit;
    logic                   r_mem_acked;

    logic [NUM_SETS-1:0]    r_valid [N_WAYS];
    logic [NUM_SETS-1:0]    r_dirty [N_WAYS];
    logic [TAG_BITS-1:0]    r_tag   [N_WAYS][NUM_SETS];

    logic [TAG_BITS-1:0]    w_tag;
    logic [INDEX_BITS-1:0]  w_idx;
    logic [OFFSET_BITS-1:0] w_off;
    logic                   w_hit0, w_hit1, w_hit, w_hit_way;
    logic                   w_lru, w_victim;
    logic                   w_mem_done;
    logic                   w_hit_upd, w_fill, w_upd_way;

    assign w_tag = r_req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign w_idx = r_req_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_off = r_req_addr[OFFSET_BITS-1:0];

    assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit     = w_hit0 | w_hit1;
    assign w_hit_way = ~w_hit0;
    assign w_victim  = !r_valid[0][w_idx] ? 1'b0 :
                       !r_valid[1][w_idx] ? 1'b1 : w_lru;
    // A response in the same cycle as the request handshake completes the transfer.
    assign w_mem_done = (r_mem_acked | cache_if.mem_req_ready) & cache_if.mem_resp_valid;

    lru_tracker #(
        .NUM_SETS   (NUM_SETS),
        .INDEX_BITS (INDEX_BITS)
    ) u_lru (
        .clk         (clk),
        .rst         (rst),
        .i_rd_index  (w_idx),
        .o_rd_lru    (w_lru),
        .i_upd_en    (w_hit_upd | w_fill),
        .i_upd_index (w_idx),
        .i_upd_way   (w_upd_way)
    );

    always_comb begin
        w_next_state            = r_state;
        w_hit_upd               = 1'b0;
        w_fill                  = 1'b0;
        w_upd_way               = r_way;
        cache_if.cpu_req_ready  = 1'b0;
        cache_if.cpu_resp_valid = 1'b0;
        cache_if.cpu_resp_hit   = 1'b0;
        cache_if.mem_req_valid  = 1'b0;
        cache_if.mem_req_we     = 1'b0;
        cache_if.mem_req_addr   = '0;
        cache_if.arr_way        = 1'b0;
        cache_if.arr_index      = '0;
        cache_if.arr_offset     = '0;
        cache_if.arr_cpu_we     = 1'b0;
        cache_if.arr_fill_we    = 1'b0;

        if (r_state != ST_IDLE) begin
            cache_if.arr_way    = r_way;
            cache_if.arr_index  = w_idx;
            cache_if.arr_offset = w_off;
        end

        case (r_state)
            ST_IDLE: begin
                cache_if.cpu_req_ready = 1'b1;
                if (cache_if.cpu_req_valid) w_next_state = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    cache_if.arr_way    = w_hit_way;
                    cache_if.arr_cpu_we = r_req_we;
                    w_hit_upd           = 1'b1;
                    w_upd_way           = w_hit_way;
                    w_next_state        = ST_RESPOND;
                end else begin
                    cache_if.arr_way = w_victim;
                    w_next_state     = (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) ?
                                       ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                cache_if.mem_req_valid = ~r_mem_acked;
                cache_if.mem_req_we    = 1'b1;
                cache_if.mem_req_addr  = {r_tag[r_way][w_idx], w_idx, {OFFSET_BITS{1'b0}}};
                if (w_mem_done) w_next_state = ST_REFILL;
            end
            ST_REFILL: begin
                cache_if.mem_req_valid = ~r_mem_acked;
                cache_if.mem_req_addr  = {w_tag, w_idx, {OFFSET_BITS{1'b0}}};
                if (w_mem_done) begin
                    cache_if.arr_fill_we = 1'b1;
                    cache_if.arr_cpu_we  = r_req_we;
                    w_fill               = 1'b1;
                    w_next_state         = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                cache_if.cpu_resp_valid = 1'b1;
                cache_if.cpu_resp_hit   = r_hit;
                w_next_state            = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_we    <= 1'b0;
            r_req_addr  <= '0;
            r_way       <= 1'b0;
            r_hit       <= 1'b0;
            r_mem_acked <= 1'b0;
            r_valid     <= '{default: '0};
            r_dirty     <= '{default: '0};
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && cache_if.cpu_req_valid) begin
                r_req_we   <= cache_if.cpu_req_we;
                r_req_addr <= cache_if.cpu_req_addr;
            end
            if (r_state == ST_LOOKUP) begin
                r_way <= w_hit ? w_hit_way : w_victim;
                r_hit <= w_hit;
            end
            // Remembers that the request was accepted while waiting for the response.
            if (r_state == ST_WRITEBACK || r_state == ST_REFILL) begin
                if (w_mem_done)                  r_mem_acked <= 1'b0;
                else if (cache_if.mem_req_ready) r_mem_acked <= 1'b1;
            end else begin
                r_mem_acked <= 1'b0;
            end
            if (w_hit_upd && r_req_we) r_dirty[w_hit_way][w_idx] <= 1'b1;
            if (w_fill) begin
                r_valid[r_way][w_idx] <= 1'b1;
                r_dirty[r_way][w_idx] <= r_req_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) r_tag[r_way][w_idx] <= w_tag;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] r_hit_count, r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == ST_RESPOND) begin
            if (r_hit && r_hit_count != '1)         r_hit_count  <= r_hit_count + 32'd1;
            else if (!r_hit && r_miss_count != '1)  r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: directed and random requests against a recency-queue cache model.
module tb_cache_controller;
    import cache_pkg::*;

    typedef struct {
        logic [19:0] tag;
        bit          dirty;
        bit          way;
    } line_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned m_hits  = 0;
    int unsigned m_misses = 0;

    // Per set: resident lines, least recently used at the front.
    line_t sets [32][$];

    cache_controller_if ifc ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_controller #(
        .ADDR_WIDTH  (32),
        .N_WAYS      (2),
        .NUM_SETS    (32),
        .OFFSET_BITS (7),
        .INDEX_BITS  (5),
        .TAG_BITS    (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cache_if   (ifc)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (sets[i]) sets[i].delete();
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifc.cpu_req_valid  = 1'b0;
        ifc.cpu_req_we     = 1'b0;
        ifc.cpu_req_addr   = '0;
        ifc.mem_req_ready  = 1'b0;
        ifc.mem_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        #1;
        chk("rst_cpu_req_ready", 64'(ifc.cpu_req_ready), 64'd1);
        chk("rst_cpu_resp_valid", 64'(ifc.cpu_resp_valid), 64'd0);
        chk("rst_mem_req_valid", 64'(ifc.mem_req_valid), 64'd0);
        chk("rst_mem_req_addr", 64'(ifc.mem_req_addr), 64'd0);
        chk("rst_arr", 64'({ifc.arr_way, ifc.arr_index, ifc.arr_offset, ifc.arr_cpu_we, ifc.arr_fill_we}), 64'd0);
`ifdef CACHE_STATS_EN
        chk("rst_counts", 64'({hit_count, miss_count}), 64'd0);
`endif
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input int unsigned rdy_dly,
                          input int unsigned rsp_dly, input bit abort);
        logic [19:0] tag;
        logic [4:0]  idx;
        int          found;
        line_t       ln;
        bit          exp_hit;
        bit          exp_way;
        logic [32:0] ops [$];
        logic [32:0] op;
        int unsigned k, vcnt, rcnt, fill_k, w;
        bit          done, waiting, busy_ok, stable_ok, cur_we, fill_now, wb_now;
        logic [31:0] cur_addr;

        tag = addr[31:12];
        idx = addr[11:7];
        found = -1;
        for (int i = 0; i < sets[idx].size(); i++) if (sets[idx][i].tag == tag) found = i;
        if (found >= 0) begin
            ln = sets[idx][found];
            sets[idx].delete(found);
            ln.dirty = ln.dirty | we;
            exp_hit = 1'b1;
        end else begin
            exp_hit = 1'b0;
            if (sets[idx].size() < 2) begin
                ln.way = (sets[idx].size() == 1 && sets[idx][0].way == 1'b0);
            end else begin
                ln = sets[idx].pop_front();
                if (ln.dirty) ops.push_back({1'b1, ln.tag, idx, 7'd0});
            end
            ops.push_back({1'b0, tag, idx, 7'd0});
            ln.tag   = tag;
            ln.dirty = we;
        end
        sets[idx].push_back(ln);
        exp_way = ln.way;

        w = 0;
        @(negedge clk);
        #1;
        while (!ifc.cpu_req_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("idle_ready", 64'(ifc.cpu_req_ready), 64'd1);
        chk("idle_mem_valid", 64'(ifc.mem_req_valid), 64'd0);
        chk("idle_arr_index", 64'(ifc.arr_index), 64'd0);
        ifc.cpu_req_valid = 1'b1;
        ifc.cpu_req_we    = we;
        ifc.cpu_req_addr  = addr;

        k = 0; done = 0; waiting = 0; vcnt = 0; rcnt = 0; fill_k = 0;
        busy_ok = 1; stable_ok = 1; cur_we = 0; cur_addr = '0;
        while (!done && k < 80) begin
            @(negedge clk);
            k++;
            ifc.cpu_req_valid  = 1'($urandom_range(0, 1));
            ifc.cpu_req_we     = 1'($urandom_range(0, 1));
            ifc.cpu_req_addr   = $urandom;
            ifc.mem_req_ready  = 1'b0;
            ifc.mem_resp_valid = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            fill_now = 0;
            wb_now   = 0;
            if (ifc.cpu_req_ready) busy_ok = 0;
            if (k == 1) begin
                chk("lookup_way", 64'(ifc.arr_way), 64'(exp_way));
                chk("lookup_index", 64'(ifc.arr_index), 64'(idx));
                chk("lookup_offset", 64'(ifc.arr_offset), 64'(addr[6:0]));
                chk("lookup_cpu_we", 64'(ifc.arr_cpu_we), 64'(exp_hit & we));
            end
            if (ifc.cpu_resp_valid) begin
                chk("resp_hit", 64'(ifc.cpu_resp_hit), 64'(exp_hit));
                chk("resp_latency", 64'(k), exp_hit ? 64'd2 : 64'(fill_k + 1));
                chk("mem_ops_left", 64'(ops.size()), 64'd0);
                if (ifc.cpu_resp_hit) m_hits++; else m_misses++;
                done = 1;
                ifc.cpu_req_valid = 1'b0;
            end else begin
                if (!waiting && ifc.mem_req_valid) begin
                    if (vcnt == 0) begin
                        cur_we   = ifc.mem_req_we;
                        cur_addr = ifc.mem_req_addr;
                        if (ops.size() == 0) begin
                            chk("unexpected_mem_req", 64'(ifc.mem_req_valid), 64'd0);
                        end else begin
                            op = ops.pop_front();
                            chk("mem_req_we", 64'(cur_we), 64'(op[32]));
                            chk("mem_req_addr", 64'(cur_addr), 64'(op[31:0]));
                        end
                        if (abort && !cur_we) begin
                            rst = 1'b1;
                            ifc.cpu_req_valid = 1'b0;
                            @(negedge clk);
                            rst = 1'b0;
                            #1;
                            chk("abort_mem_valid", 64'(ifc.mem_req_valid), 64'd0);
                            chk("abort_cpu_ready", 64'(ifc.cpu_req_ready), 64'd1);
                            model_clear();
                            done = 1;
                        end
                    end else if ({ifc.mem_req_we, ifc.mem_req_addr} != {cur_we, cur_addr}) begin
                        stable_ok = 0;
                    end
                    if (!done) begin
                        if (vcnt == rdy_dly) begin
                            ifc.mem_req_ready = 1'b1;
                            waiting = 1;
                            rcnt = 0;
                        end
                        vcnt++;
                    end
                end
                if (waiting && !done) begin
                    if (rcnt == rsp_dly) begin
                        ifc.mem_resp_valid = 1'b1;
                        waiting  = 0;
                        vcnt     = 0;
                        fill_now = !cur_we;
                        wb_now   = cur_we;
                    end else begin
                        rcnt++;
                    end
                end
                #1;
                if (fill_now) begin
                    chk("fill_we", 64'(ifc.arr_fill_we), 64'd1);
                    chk("fill_cpu_we", 64'(ifc.arr_cpu_we), 64'(we));
                    chk("fill_way", 64'(ifc.arr_way), 64'(exp_way));
                    chk("fill_index", 64'(ifc.arr_index), 64'(idx));
                    fill_k = k;
                end else if (wb_now) begin
                    chk("wb_no_fill", 64'(ifc.arr_fill_we), 64'd0);
                end
            end
        end
        chk("resp_timeout", 64'(done), 64'd1);
        chk("busy_cpu_ready_low", 64'(busy_ok), 64'd1);
        chk("mem_req_stable", 64'(stable_ok), 64'd1);
    endtask

    initial begin
        logic [4:0]  idx_pool [3];
        logic [31:0] a;

        idx_pool[0] = 5'd1;
        idx_pool[1] = 5'd2;
        idx_pool[2] = 5'd5;

        do_reset();

        do_req(1'b0, 32'h0000_1080, 0, 1, 1'b0);
        do_req(1'b0, 32'h0000_1080, 0, 0, 1'b0);

        do_req(1'b1, 32'h0000_1080, 0, 0, 1'b0);
        do_req(1'b0, 32'h0010_1080, 1, 1, 1'b0);
        do_req(1'b0, 32'h0020_1080, 0, 1, 1'b0);

        do_req(1'b1, 32'h0030_1080, 5, 2, 1'b0);
        do_req(1'b0, 32'h0040_1080, 2, 1, 1'b0);
        do_req(1'b0, 32'h0050_1080, 5, 2, 1'b0);

        do_req(1'b0, 32'h0000_2100, 0, 0, 1'b0);
        do_req(1'b1, 32'h0000_2104, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = {20'($urandom_range(1, 4)), idx_pool[$urandom_range(0, 2)], 7'($urandom)};
            do_req(1'($urandom_range(0, 1)), a, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        do_req(1'b0, 32'h0070_2880, 1, 1, 1'b1);
        do_req(1'b0, 32'h0070_2880, 0, 0, 1'b0);

        do_reset();
        do_req(1'b0, 32'h0001_0080, 0, 0, 1'b0);
        do_req(1'b0, 32'h0001_0100, 1, 0, 1'b0);
        do_req(1'b1, 32'h0001_0180, 0, 1, 1'b0);
        do_req(1'b0, 32'h0001_0080, 0, 0, 1'b0);
        do_req(1'b1, 32'h0001_0100, 0, 0, 1'b0);
        do_req(1'b0, 32'h0001_0180, 0, 0, 1'b0);
        do_req(1'b0, 32'h0001_00C0, 0, 0, 1'b0);
        @(negedge clk);
        #1;
`ifdef CACHE_STATS_EN
        chk("miss_count", 64'(miss_count), 64'(m_misses));
        chk("hit_count", 64'(hit_count), 64'(m_hits));
`endif
        chk("final_idle_ready", 64'(ifc.cpu_req_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
